calc_seq: RTL and testbench

CALC_SEQ -- requirements
Module: calc_seq

---
 rtl/calc_seq.sv | 148 ++++++++++++++
 tb/tb_calc_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// calc_seq: three-state sequencer that feeds operands to an external
// combinational 4-bit ALU and returns the captured result.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (accepted only in IDLE)
//   in_a, in_b, in_op   operands and op (00 add, 01 sub, 10 OR, 11 -A)
//   in_chain            take A from the previous result (chaining build only)
//   alu_a/alu_b/alu_op  registered operands driven to the ALU
//   alu_out             combinational ALU result
//   out_valid/out_ready result handshake (completed only in HOLD)
//   out_result,out_flag captured result; carry (add) / borrow (sub), else 0
//   op_count            completed result handshakes, wraps at 256
//
// Build option: define CALC_SEQ_CHAIN_EN to enable result chaining. Without
// it in_chain is ignored and no last-result register exists.
//
// state | meaning
// IDLE  | ready for a new operation; ALU operands hold last latched values
// ISSUE | latched operands on the ALU; result captured at the next edge
// HOLD  | result presented until the consumer takes it
module calc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [1:0] in_op,
  input  logic       in_chain,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic       out_flag,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [3:0] result_q, result_d;
  logic       flag_q, flag_d;
  logic [7:0] count_q, count_d;
  logic [3:0] a_src;
  logic [4:0] sum_ext;

`ifdef CALC_SEQ_CHAIN_EN
  logic [3:0] last_q, last_d;
  assign a_src = in_chain ? last_q : in_a;
`else
  logic unused_chain;
  assign unused_chain = in_chain;
  assign a_src = in_a;
`endif

  // Carry is bit 4 of the 5-bit unsigned sum of the latched operands.
  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flag_d   = flag_q;
    count_d  = count_q;
`ifdef CALC_SEQ_CHAIN_EN
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_src;
          // Complement ignores B, so the ALU sees a clean zero operand.
          b_d     = (in_op == 2'b11) ? 4'b0000 : in_b;
          op_d    = in_op;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        result_d = alu_out;
        case (op_q)
          2'b00:   flag_d = sum_ext[4];
          2'b01:   flag_d = (a_q < b_q);
          default: flag_d = 1'b0;
        endcase
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          count_d = count_q + 8'd1;
`ifdef CALC_SEQ_CHAIN_EN
          last_d  = result_q;
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 2'd0;
      result_q <= 4'd0;
      flag_q   <= 1'b0;
      count_q  <= 8'd0;
`ifdef CALC_SEQ_CHAIN_EN
      last_q   <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      count_q  <= count_d;
`ifdef CALC_SEQ_CHAIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_HOLD);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign out_result = result_q;
  assign out_flag   = flag_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_calc_seq.sv
module tb_calc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [1:0] in_op;
  logic       in_chain;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_flag;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb[$];       // {flag, result}
  logic [7:0] exp_count;

  calc_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flag(out_flag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    alu_out = 4'd0;
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = 4'(~alu_a + 4'd1);
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ref_calc(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), 4'(a - b)};
      2'b10:   r = {1'b0, a | b};
      default: r = {1'b0, 4'(~a + 4'd1)};
    endcase
    return r;
  endfunction

  // Monitor: compare every completed result handshake against the scoreboard.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      exp_count = 8'd0;
      sb.delete();
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_result", out_result, e[3:0]);
        chk("out_flag", out_flag, e[4]);
        chk("op_count_at_hold", op_count, exp_count);
      end
      exp_count = exp_count + 8'd1;
    end
  end

  // Issue one operation; returns at the negedge in HOLD.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic ch, input logic [3:0] er, input logic ef);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_chain = ch;
    sb.push_back({ef, er});
    tick();
    // Garbage during ISSUE must not disturb the operation.
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = op + 2'd1; in_chain = ~ch;
    @(negedge clk);
    chk("issue_out_valid", out_valid, 0);
    chk("issue_in_ready", in_ready, 0);
    chk("issue_alu_op", alu_op, op);
    chk("issue_alu_b", alu_b, (op == 2'b11) ? 4'd0 : b);
    tick();
    @(negedge clk);
    chk("hold_out_valid", out_valid, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r;
    rst = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; in_op = 2'd0;
    in_chain = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flag", out_flag, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);

    // Add without and with carry
    do_op(4'b0111, 4'b0101, 2'b00, 1'b0, 4'b1100, 1'b0);
    @(negedge clk);
    chk("count_after_first", op_count, 1);
    chk("idle_alu_a_held", alu_a, 4'b0111);
    do_op(4'b1111, 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b1);
    // Sub with borrow, OR, complement
    do_op(4'b0011, 4'b0101, 2'b01, 1'b0, 4'b1110, 1'b1);
    do_op(4'b1010, 4'b0101, 2'b10, 1'b0, 4'b1111, 1'b0);
    do_op(4'b0011, 4'b1111, 2'b11, 1'b0, 4'b1101, 1'b0);

    // Backpressure in HOLD with noisy inputs
    tick();
    out_ready = 1'b0;
    do_op(4'b0110, 4'b0011, 2'b00, 1'b0, 4'b1001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b1; in_a = 4'(i); in_b = 4'(15 - i); in_op = 2'(i); in_chain = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_result", out_result, 4'b1001);
    end
    tick();
    in_valid = 1'b0; in_chain = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", in_ready, 1);
    chk("bp_count", op_count, 6);

    // Chaining
    do_op(4'b0111, 4'b0101, 2'b00, 1'b0, 4'b1100, 1'b0);
`ifdef CALC_SEQ_CHAIN_EN
    do_op(4'b0001, 4'b0010, 2'b01, 1'b1, 4'b1010, 1'b0);
`else
    do_op(4'b0001, 4'b0010, 2'b01, 1'b1, 4'b1111, 1'b1);
`endif

    // Reset while in HOLD discards the operation
    tick();
    out_ready = 1'b0;
    do_op(4'b0010, 4'b0010, 2'b00, 1'b0, 4'b0100, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("hold_rst_out_valid", out_valid, 0);
    chk("hold_rst_in_ready", in_ready, 1);
    chk("hold_rst_op_count", op_count, 0);
    chk("hold_rst_out_result", out_result, 0);
    chk("hold_rst_alu_a", alu_a, 0);
    tick();
    out_ready = 1'b1;

    // 256 completions wrap op_count to zero
    for (int i = 0; i < 256; i++) begin
      r = ref_calc(4'(i), 4'(i >> 4), 2'(i >> 2));
      do_op(4'(i), 4'(i >> 4), 2'(i >> 2), 1'b0, r[3:0], r[4]);
    end
    @(negedge clk);
    chk("wrap_count", op_count, 0);
    chk("wrap_idle", in_ready, 1);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
